// File: rtl/gmii_pkg.sv
// gmii_pkg: shared GMII framing constants, receive state encoding and CRC-32 byte step.
package gmii_pkg;
  localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0] SFD_BYTE = 8'hD5;
  localparam logic [31:0] CRC_INIT = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_POLY = 32'h04C11DB7;
  typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, DISCARD} state_t;
  function automatic logic [31:0] crc32_d8(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] poly_ref;
    logic [31:0] c;
    for (int i = 0; i < 32; i++) poly_ref[i] = CRC_POLY[31-i];
    c = crc ^ {24'h0, data};
    for (int i = 0; i < 8; i++) c = c[0] ? (c >> 1) ^ poly_ref : c >> 1;
    return c;
  endfunction
endpackage

// File: rtl/crc32_d8_reg.sv
// crc32_d8_reg: byte-wide reflected CRC-32 register; crc_out is the complemented FCS.
module crc32_d8_reg
  import gmii_pkg::*;
(
  input  logic        clk_125m,
  input  logic        rst,
  input  logic        clr,
  input  logic        en,
  input  logic [7:0]  data_in,
  output logic [31:0] crc_out
);
  logic [31:0] crc;
  always_ff @(posedge clk_125m)
    if (rst || clr) crc <= CRC_INIT;
    else if (en) crc <= crc32_d8(crc, data_in);
  assign crc_out = ~crc;
endmodule

// File: rtl/gmii_rx.sv
// gmii_rx: GMII receive framer stripping preamble/SFD/FCS with CRC, length and PHY error status.
module gmii_rx
  import gmii_pkg::*;
#(
  parameter int unsigned MIN_LEN = 1,
  parameter int unsigned MAX_LEN = 1514
) (
  input  logic        clk_125m,
  input  logic        rst,
  input  logic [7:0]  rxd,
  input  logic        rx_dv,
  input  logic        rx_er,
  output logic [7:0]  out_data,
  output logic        out_valid,
  output logic        out_sof,
  output logic        frame_done,
  output logic        frame_ok,
  output logic        crc_err,
  output logic        len_err,
  output logic        phy_err,
  output logic [10:0] frame_len
);
  localparam logic [10:0] MIN_L = 11'(MIN_LEN);
  localparam logic [10:0] MAX_L = 11'(MAX_LEN);
  state_t state, state_nxt;
  logic [2:0] pre_cnt, fill;
  logic [31:0] line, fcs;
  logic [10:0] cnt;
  logic phy, sfd, push, eof, emit, crc_bad, len_bad;
  crc32_d8_reg u_crc (
    .clk_125m(clk_125m),
    .rst(rst),
    .clr(sfd),
    .en(push),
    .data_in(line[7:0]),
    .crc_out(fcs)
  );
  always_comb begin
    state_nxt = state;
    sfd = 1'b0;
    push = 1'b0;
    eof = 1'b0;
    case (state)
      IDLE: state_nxt = !rx_dv ? IDLE : rxd == PREAMBLE_BYTE ? PREAMBLE : DISCARD;
      PREAMBLE: begin
        sfd = rx_dv && rxd == SFD_BYTE;
        state_nxt = !rx_dv ? IDLE : sfd ? DATA :
                    (rxd == PREAMBLE_BYTE && pre_cnt != 3'd7) ? PREAMBLE : DISCARD;
      end
      DATA: begin
        push = rx_dv && fill == 3'd4;
        eof = !rx_dv;
        state_nxt = rx_dv ? DATA : IDLE;
      end
      default: state_nxt = rx_dv ? DISCARD : IDLE;
    endcase
  end
  // line[7:0] is the oldest byte; once the FCS has arrived the line equals the FCS word
  assign emit = push && cnt < MAX_L;
  assign crc_bad = fill != 3'd4 || line != fcs;
  assign len_bad = fill != 3'd4 || cnt < MIN_L || cnt > MAX_L;
  always_ff @(posedge clk_125m) begin
    if (rst) begin
      state <= IDLE;
      pre_cnt <= '0;
      fill <= '0;
      line <= '0;
      cnt <= '0;
      phy <= 1'b0;
      out_data <= '0;
      out_valid <= 1'b0;
      out_sof <= 1'b0;
      frame_done <= 1'b0;
      frame_ok <= 1'b0;
      crc_err <= 1'b0;
      len_err <= 1'b0;
      phy_err <= 1'b0;
      frame_len <= '0;
    end else begin
      state <= state_nxt;
      pre_cnt <= state == PREAMBLE ? pre_cnt + 3'd1 : 3'd1;
      out_valid <= emit;
      out_sof <= emit && cnt == '0;
      if (emit) out_data <= line[7:0];
      if (sfd) begin
        fill <= '0;
        line <= '0;
        cnt <= '0;
        phy <= 1'b0;
      end else if (state == DATA && rx_dv) begin
        line <= {rxd, line[31:8]};
        if (fill != 3'd4) fill <= fill + 3'd1;
        if (push && cnt != 11'h7FF) cnt <= cnt + 11'd1;
        if (rx_er) phy <= 1'b1;
      end
      frame_done <= eof;
      if (eof) begin
        frame_len <= cnt;
        crc_err <= crc_bad;
        len_err <= len_bad;
        phy_err <= phy;
        frame_ok <= !(crc_bad || len_bad || phy);
      end
    end
  end
endmodule

// File: doc/gmii_rx.md
Name: gmii_rx

Overview:
- GMII receive framer, directly downstream of the GMII transmitter; consumes rxd/rx_dv/rx_er at 125 MHz.
- Strips the preamble and SFD, and passes payload bytes downstream with the 4 FCS bytes removed.
- Checks the IEEE 802.3 CRC-32 and payload length, then reports a one-cycle per-frame status.
- Used in loopback against the transmitter and as the receive path toward user logic.

Parameters:
MIN_LEN, 1, minimum accepted payload bytes, FCS excluded
MAX_LEN, 1514, maximum accepted payload bytes, FCS excluded; at most 2043

Ports:
clk_125m  in  1  125 MHz GMII clock; the only clock
rst  in  1  synchronous reset, active-high
rxd  in  8  GMII receive data
rx_dv  in  1  GMII data valid
rx_er  in  1  GMII receive error
out_data  out  8  payload byte
out_valid  out  1  out_data is valid this cycle
out_sof  out  1  first payload byte of the frame; qualified by out_valid
frame_done  out  1  one-cycle end-of-frame status strobe
frame_ok  out  1  no crc_err, len_err or phy_err; valid with frame_done
crc_err  out  1  FCS mismatch
len_err  out  1  payload count outside [MIN_LEN, MAX_LEN]
phy_err  out  1  rx_er was seen between SFD and end of frame
frame_len  out  11  payload byte count (FCS excluded), saturating at 2047

Behaviour:
- Clock and reset: single clock clk_125m; reset rst is synchronous and active-high. All inputs are sampled on the rising edge.
- Reset values: every output is 0, state is IDLE, and the delay line, counters and CRC are cleared.
- Reset asserted mid-frame: outputs go to 0 at once and no frame_done is issued for that frame.
- States: IDLE, PREAMBLE, DATA, DISCARD.
- IDLE: on rx_dv=1, byte 0x55 -> PREAMBLE; any other byte -> DISCARD.
- PREAMBLE:
  - 0x55 -> stay, up to 7 total bytes of 0x55.
  - 0xD5 -> DATA.
  - Any other byte, or an 8th 0x55 -> DISCARD.
  - rx_dv=0 -> IDLE, no status.
- DISCARD: ignore input until rx_dv=0, then go to IDLE. No out_valid and no frame_done.
- DATA, delay line:
  - Each byte with rx_dv=1 enters a 4-byte shift line.
  - Once the line holds 4 bytes, each new byte pushes the oldest byte to out_data with out_valid=1, registered.
  - Net effect: payload byte i appears the cycle after byte i+4 is sampled on rxd.
  - out_sof accompanies payload byte 0.
  - The last 4 bytes of the frame (the FCS) are never output.
  - Payload bytes beyond MAX_LEN are not output but are still counted.
- DATA, CRC:
  - The CRC is updated with each byte as it leaves the delay line.
  - Init 0xFFFFFFFF, reflected, final complement; the result is the standard FCS value.
- End of frame (first sample with rx_dv=0 in DATA):
  - The held 4 bytes are compared against the FCS as h0=FCS[7:0], h1=FCS[15:8], h2=FCS[23:16], h3=FCS[31:24].
  - Next cycle: frame_done=1 for one cycle with frame_len and the flags; state -> IDLE.
  - Flags and frame_len hold their values until the next frame_done or reset.
- Short frames: fewer than 4 bytes after SFD gives frame_len=0, crc_err=1, len_err=1.
- phy_err: rx_er=1 while rx_dv=1 in DATA sets phy_err. Reception continues to the end of frame.
- rx_er outside DATA is ignored.
- Back-to-back frames: frame_done of frame N may coincide with IDLE sampling frame N+1's first preamble byte; both must be handled.
- Inter-frame gap: a minimum of 1 cycle with rx_dv=0 between frames is supported.
- Throughput: 1 byte/cycle, no backpressure.

Decomposition:
- Shared package gmii_pkg holds:
  - constants PREAMBLE_BYTE=8'h55, SFD_BYTE=8'hD5, CRC_INIT=32'hFFFFFFFF, CRC_POLY=32'h04C11DB7;
  - the state enum encoding;
  - the function crc32_d8(crc, data), which returns the next reflected CRC register.
- Sub-module crc32_d8_reg: 32-bit CRC register with ports clk_125m, rst, clr, en, data_in[7:0], crc_out[31:0] (complemented FCS).
  - Same polarity conventions as this block; reusable by a future transmitter revision.

Test Plan:
1. Frame "55x7 D5 31 32 ... 39 26 39 F4 CB", MIN_LEN=1 -> out_data 0x31..0x39 on 9 consecutive cycles, out_sof on 0x31; frame_done with frame_ok=1, frame_len=9, all error flags 0.
2. Same frame with the last byte 0xCA -> same 9 payload bytes; crc_err=1, frame_ok=0.
3. Input "55 55 AA 31 32 33" -> no out_valid, no frame_done; the following good frame is received with frame_ok=1.
4. rx_er=1 on the cycle carrying payload byte 0x33 of frame 1 -> phy_err=1, crc_err=0, frame_ok=0, frame_len=9.
5. Input "55x7 D5 AB CD" -> no out_valid; frame_done with frame_len=0, crc_err=1, len_err=1.
6. Two good frames separated by 1 idle cycle -> two frame_done strobes, both frame_ok=1. Then rst high for 1 cycle mid-payload of a third frame -> outputs 0, rest of that frame discarded, no status; a fourth frame is received with frame_ok=1.
